// File: rtl/fixed_point_divider.sv
// Iterative signed Q(WIDTH-FBITS).FBITS divider, restoring algorithm, one quotient bit per clock.
// Latency: WIDTH+FBITS+1 edges from the accepting edge to ready (1 edge for divide-by-zero).
// Backpressure: none; start is sampled only while idle and is ignored while busy.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start              request, accepted only in IDLE
//   operand_1/2        dividend / divisor, signed fixed point
//   result             saturated quotient truncated toward zero, held until next completion
//   ready              one-cycle pulse when result and flags are valid
//   busy               high from the accepting edge until the ready pulse
//   div_by_zero        last operation had a zero divisor
//   overflow           last operation saturated
module fixed_point_divider #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int NW = WIDTH + FBITS;
  localparam int CW = $clog2(NW + 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic             op1_neg_q, op1_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [NW-1:0]    num_q, num_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [NW-1:0]    quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
  logic             q_hi, pos_ov, neg_ov;

  // After every subtraction the remainder is below the divisor, so its top
  // bit is structurally zero and never feeds the next shift.
  logic rem_msb_unused;
  assign rem_msb_unused = rem_q[WIDTH];

  // Magnitudes as unsigned; the most negative value maps to 2^(WIDTH-1).
  assign mag1 = operand_1[WIDTH-1] ? -operand_1 : operand_1;
  assign mag2 = operand_2[WIDTH-1] ? -operand_2 : operand_2;

  assign rem_sh  = {rem_q[WIDTH-1:0], num_q[NW-1]};
  assign rem_ge  = (rem_sh >= {1'b0, den_q});
  assign rem_sub = rem_sh - {1'b0, den_q};

  // Positive results saturate above 2^(W-1)-1, negative ones above 2^(W-1).
  assign q_hi   = |quo_q[NW-1:WIDTH];
  assign pos_ov = q_hi | quo_q[WIDTH-1];
  assign neg_ov = q_hi | (quo_q[WIDTH-1] & (|quo_q[WIDTH-2:0]));

  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    op1_neg_d     = op1_neg_q;
    dz_d          = dz_q;
    den_d         = den_q;
    num_d         = num_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    ready_d       = 1'b0;
    busy_d        = busy_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d        = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
          op1_neg_d     = operand_1[WIDTH-1];
          den_d         = mag2;
          num_d         = {mag1, {FBITS{1'b0}}};
          rem_d         = '0;
          quo_d         = '0;
          busy_d        = 1'b1;
          div_by_zero_d = 1'b0;
          overflow_d    = 1'b0;
          if (operand_2 == '0) begin
            dz_d    = 1'b1;
            cnt_d   = '0;
            state_d = FIXUP;
          end else begin
            dz_d    = 1'b0;
            cnt_d   = CW'(NW);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d = rem_ge ? rem_sub : rem_sh;
        quo_d = {quo_q[NW-2:0], rem_ge};
        num_d = {num_q[NW-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (dz_q) begin
          result_d      = op1_neg_q ? MAX_NEG : MAX_POS;
          div_by_zero_d = 1'b1;
          overflow_d    = 1'b0;
        end else if (!sign_q && pos_ov) begin
          result_d   = MAX_POS;
          overflow_d = 1'b1;
        end else if (sign_q && neg_ov) begin
          result_d   = MAX_NEG;
          overflow_d = 1'b1;
        end else begin
          result_d = sign_q ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
        end
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      op1_neg_q     <= 1'b0;
      dz_q          <= 1'b0;
      den_q         <= '0;
      num_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      op1_neg_q     <= op1_neg_d;
      dz_q          <= dz_d;
      den_q         <= den_d;
      num_q         <= num_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign result      = result_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Iterative signed fixed-point divider for the Q22.10 datapath (WIDTH=32, FBITS=10).
- Computes result = operand_1 / operand_2, with the quotient truncated toward zero.
- It is the inverse companion of the fixed-point unit's multiplier, and sits beside that unit behind the same operand buses.
- Uses a start/ready handshake with one quotient bit per clock (restoring division), and saturates on overflow and on divide-by-zero.

Parameters:
- WIDTH, 32: operand and result width in bits, two's-complement fixed point.
- FBITS, 10: number of fractional bits; the integer part is WIDTH-FBITS bits including sign.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: reset, asynchronous, active-high.
- start, input, 1: request pulse or level; sampled only in IDLE.
- operand_1, input, WIDTH: dividend, Q(WIDTH-FBITS).FBITS signed.
- operand_2, input, WIDTH: divisor, same format.
- result, output, WIDTH: quotient, held until the next accepted start.
- ready, output, 1: single-cycle pulse, result valid.
- busy, output, 1: high from the accepted start until the ready pulse (exclusive).
- div_by_zero, output, 1: status of the last completed operation; valid while ready=1 and held afterward.
- overflow, output, 1: status of the last completed operation; saturation occurred.

Behaviour:
- Reset (async):
  - state=IDLE.
  - result=0, ready=0, busy=0, div_by_zero=0, overflow=0.
  - Iteration counter and work registers are cleared.
  - Reset asserted mid-operation aborts the operation: no ready pulse, and no result update after release.
- States: IDLE, ITER, FIXUP.
- IDLE, start=1 at edge E0:
  - Latch sign_q = operand_1[MSB] ^ operand_2[MSB].
  - Latch the magnitudes |op1| and |op2| as WIDTH-bit unsigned values; |0x80000000| = 2^31 is legal.
  - Form numerator N = |op1| << FBITS (WIDTH+FBITS bits).
  - Clear the partial remainder and quotient; set busy=1; clear div_by_zero and overflow.
  - If operand_2 == 0: go to FIXUP with the dz flag set. Otherwise go to ITER with count = WIDTH+FBITS.
- IDLE, start=0: hold all outputs.
- ITER, one edge per quotient bit, MSB first:
  - rem = {rem, N[MSB]} and shift N left.
  - If rem >= |op2|: subtract |op2| from rem and shift in quotient bit 1. Otherwise shift in 0.
  - Decrement count; on the edge where count reaches 0, go to FIXUP.
  - The remainder register is WIDTH+1 bits.
- FIXUP, one edge:
  - Divide-by-zero: result = 0x7FFFFFFF if operand_1 >= 0, else 0x80000000; div_by_zero=1; overflow=0.
  - Else, if sign_q=0 and q > 2^(WIDTH-1)-1: result = 0x7FFFFFFF, overflow=1.
  - Else, if sign_q=1 and q > 2^(WIDTH-1): result = 0x80000000, overflow=1.
  - Otherwise: result = sign_q ? -q[WIDTH-1:0] : q[WIDTH-1:0].
  - A zero quotient with sign_q=1 gives result 0.
  - Set ready=1, busy=0, state=IDLE.
- ready deasserts on the following edge.
- Latency from the start-sampling edge E0 to the ready-asserting edge:
  - Normal operation: WIDTH+FBITS+1 = 43 edges.
  - Divide-by-zero: 1 edge.
- start while busy=1 is ignored; the operands are not re-sampled.
- Back-to-back operation: start high during the ready cycle (state already IDLE) is accepted. ready drops and busy rises on that same edge.
- Operands may change after E0 without affecting the operation in flight.
- Rounding is truncation toward zero, applied to the magnitude before the sign is applied.

Test Plan:
- 6.0/2.0: op1=0x00001800, op2=0x00000800, start for 1 cycle -> ready exactly 43 edges later, result=0x00000C00, both flags 0, busy high for 43 cycles.
- -7.5/2.0: op1=0xFFFFE200, op2=0x00000800 -> result=0xFFFFF100 (-3.75). 1/3: op1=0x400, op2=0xC00 -> result=0x00000155 (truncated).
- Divide by zero:
  - op1=0x1800, op2=0 -> ready on the 1st edge, result=0x7FFFFFFF, div_by_zero=1.
  - op1=0xFFFFF000, op2=0 -> result=0x80000000.
- Overflow and boundary:
  - op1=0x7FFFFFFF, op2=0x00000001 -> result=0x7FFFFFFF, overflow=1.
  - op1=0x80000000, op2=0x00000400 (1.0) -> result=0x80000000, overflow=0.
  - op1=0x80000000, op2=0xFFFFFC00 (-1.0) -> result=0x7FFFFFFF, overflow=1.
- Reset at ITER edge 20 of a 6.0/2.0 operation -> outputs immediately 0, no ready pulse; a new start after release yields the correct 0xC00 in 43 edges.
- Handshake:
  - A second start at edges 5..42 with different operands is ignored, and the first result is delivered.
  - start held high through ready -> the next operation begins on the ready cycle, and its ready arrives 43 edges after that.
